// File: rtl/connect4_turn_ctrl_if.sv
// Command bus between the turn controller and the connect-four game FSM.
// The controller is the master: it drives the command pulses and the timer display.
interface connect4_turn_ctrl_if;
  logic       player_turn;
  logic [2:0] fsm_state;
  logic       win_flag;
  logic       move_left;
  logic       move_right;
  logic       move_made;
  logic       times_up;
  logic [3:0] seconds_left;
  logic       timer_active;

  modport master (
    input  player_turn, fsm_state, win_flag,
    output move_left, move_right, move_made, times_up, seconds_left, timer_active
  );

  modport slave (
    output player_turn, fsm_state, win_flag,
    input  move_left, move_right, move_made, times_up, seconds_left, timer_active
  );
endinterface

// File: rtl/connect4_turn_ctrl.sv
// Input conditioning, player selection and per-turn countdown in front of the game FSM.
// Turns raw button presses into single-cycle commands and raises times_up when a turn expires.
module connect4_turn_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECONDS  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic p1_left,
  input  logic p1_right,
  input  logic p1_drop,
  input  logic p2_left,
  input  logic p2_right,
  input  logic p2_drop,
  connect4_turn_ctrl_if.master bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] TURN_LOAD = 4'(TURN_SECONDS);
  localparam logic [2:0] PLAYER_TURN = 3'd1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    WAIT_ACK,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [5:0] raw_btn;
  logic [5:0] sync1, sync2, prev;
  logic [5:0] edges;
  logic [2:0] sel_edges;
  logic       sel_left, sel_right, sel_drop;

  logic [PW-1:0] prescaler, pre_nxt;
  logic          tick;
  logic [3:0]    seconds_q, sec_nxt;
  logic          left_q, right_q, made_q, tup_q, active_q;
  logic          left_nxt, right_nxt, made_nxt, tup_nxt, active_nxt;

  // Bit order: player 1 in [2:0], player 2 in [5:3], each {drop, right, left}.
  assign raw_btn = {p2_drop, p2_right, p2_left, p1_drop, p1_right, p1_left};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // prev runs in every state, so a button already held when a turn arms never edges.
  assign edges     = sync2 & ~prev;
  assign sel_edges = bus.player_turn ? edges[5:3] : edges[2:0];
  assign sel_left  = sel_edges[0];
  assign sel_right = sel_edges[1];
  assign sel_drop  = sel_edges[2];
  assign tick      = (prescaler == PRE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prescaler <= '0;
      seconds_q <= '0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      made_q    <= 1'b0;
      tup_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      prescaler <= pre_nxt;
      seconds_q <= sec_nxt;
      left_q    <= left_nxt;
      right_q   <= right_nxt;
      made_q    <= made_nxt;
      tup_q     <= tup_nxt;
      active_q  <= active_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pre_nxt   = prescaler;
    sec_nxt   = seconds_q;
    left_nxt  = 1'b0;
    right_nxt = 1'b0;
    made_nxt  = 1'b0;
    tup_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.fsm_state == PLAYER_TURN && !bus.win_flag) begin
          state_nxt = COUNT;
          sec_nxt   = TURN_LOAD;
          pre_nxt   = '0;
        end
      end

      COUNT: begin
        // A drop wins over navigation and over the final tick; the timer freezes.
        if (sel_drop) begin
          made_nxt  = 1'b1;
          state_nxt = WAIT_ACK;
        end else if (bus.fsm_state != PLAYER_TURN) begin
          state_nxt = IDLE;
        end else begin
          if (tick) begin
            pre_nxt = '0;
            sec_nxt = seconds_q - 4'd1;
          end else begin
            pre_nxt = prescaler + PW'(1);
          end

          if (tick && seconds_q == 4'd1) begin
            tup_nxt   = 1'b1;
            state_nxt = WAIT_ACK;
          end else begin
            left_nxt  = sel_left & ~sel_right;
            right_nxt = sel_right & ~sel_left;
          end
        end
      end

      WAIT_ACK: begin
        if (bus.fsm_state != PLAYER_TURN) begin
          state_nxt = IDLE;
        end
      end

      DONE: begin
        sec_nxt = '0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Game over locks the block until reset and swallows any pulse due this cycle.
    if (bus.win_flag) begin
      state_nxt = DONE;
      sec_nxt   = '0;
      left_nxt  = 1'b0;
      right_nxt = 1'b0;
      made_nxt  = 1'b0;
      tup_nxt   = 1'b0;
    end

    active_nxt = (state_nxt == COUNT);
  end

  assign bus.move_left    = left_q;
  assign bus.move_right   = right_q;
  assign bus.move_made    = made_q;
  assign bus.times_up     = tup_q;
  assign bus.seconds_left = seconds_q;
  assign bus.timer_active = active_q;

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Directed bench for connect4_turn_ctrl with a 4-cycle second and a 3-second turn.
module tb_connect4_turn_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] btn;
  int         checks;
  int         errors;
  int         cnt;

  connect4_turn_ctrl_if bus ();

  connect4_turn_ctrl #(
    .TICKS_PER_SEC(4),
    .TURN_SECONDS (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .p1_left (btn[0]),
    .p1_right(btn[1]),
    .p1_drop (btn[2]),
    .p2_left (btn[3]),
    .p2_right(btn[4]),
    .p2_drop (btn[5]),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic arm;
    bus.fsm_state = 3'd1;
    step();
  endtask

  task automatic ack;
    bus.fsm_state = 3'd2;
    step();
    bus.fsm_state = 3'd0;
    step();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    btn = '0;
    bus.player_turn = 1'b0;
    bus.fsm_state = 3'd0;
    bus.win_flag = 1'b0;
    step();
    step();
    checks++; if (bus.move_left !== 1'b0) begin errors++; $display("[TB] FAIL reset_move_left: got %b expected 0", bus.move_left); end
    checks++; if (bus.move_right !== 1'b0) begin errors++; $display("[TB] FAIL reset_move_right: got %b expected 0", bus.move_right); end
    checks++; if (bus.move_made !== 1'b0) begin errors++; $display("[TB] FAIL reset_move_made: got %b expected 0", bus.move_made); end
    checks++; if (bus.times_up !== 1'b0) begin errors++; $display("[TB] FAIL reset_times_up: got %b expected 0", bus.times_up); end
    checks++; if (bus.seconds_left !== 4'd0) begin errors++; $display("[TB] FAIL reset_seconds: got %0d expected 0", bus.seconds_left); end
    checks++; if (bus.timer_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", bus.timer_active); end
    #2 reset = 1'b1;
    step();
    checks++; if (bus.timer_active !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_arm: got %b expected 0", bus.timer_active); end
  endtask

  task automatic test_timeout;
    arm();
    checks++; if (bus.timer_active !== 1'b1) begin errors++; $display("[TB] FAIL arm_active: got %b expected 1", bus.timer_active); end
    checks++; if (bus.seconds_left !== 4'd3) begin errors++; $display("[TB] FAIL arm_seconds: got %0d expected 3", bus.seconds_left); end
    repeat (3) step();
    checks++; if (bus.seconds_left !== 4'd3) begin errors++; $display("[TB] FAIL sec_before_tick: got %0d expected 3", bus.seconds_left); end
    step();
    checks++; if (bus.seconds_left !== 4'd2) begin errors++; $display("[TB] FAIL sec_tick1: got %0d expected 2", bus.seconds_left); end
    repeat (4) step();
    checks++; if (bus.seconds_left !== 4'd1) begin errors++; $display("[TB] FAIL sec_tick2: got %0d expected 1", bus.seconds_left); end
    repeat (3) step();
    checks++; if (bus.times_up !== 1'b0) begin errors++; $display("[TB] FAIL times_up_early: got %b expected 0", bus.times_up); end
    step();
    checks++; if (bus.times_up !== 1'b1) begin errors++; $display("[TB] FAIL times_up_pulse: got %b expected 1", bus.times_up); end
    checks++; if (bus.seconds_left !== 4'd0) begin errors++; $display("[TB] FAIL sec_zero: got %0d expected 0", bus.seconds_left); end
    step();
    checks++; if (bus.times_up !== 1'b0) begin errors++; $display("[TB] FAIL times_up_width: got %b expected 0", bus.times_up); end
    checks++; if (bus.timer_active !== 1'b0) begin errors++; $display("[TB] FAIL wait_ack_active: got %b expected 0", bus.timer_active); end
    repeat (3) step();
    checks++; if (bus.timer_active !== 1'b0) begin errors++; $display("[TB] FAIL wait_ack_no_rearm: got %b expected 0", bus.timer_active); end
    ack();
  endtask

  task automatic test_player_filter;
    bus.player_turn = 1'b0;
    arm();
    btn[5] = 1'b1;
    step();
    btn = '0;
    cnt = 0;
    repeat (4) begin step(); cnt += int'(bus.move_made); end
    checks++; if (cnt !== 0) begin errors++; $display("[TB] FAIL filter_p2_drop: got %0d pulses expected 0", cnt); end
    checks++; if (bus.timer_active !== 1'b1) begin errors++; $display("[TB] FAIL filter_active: got %b expected 1", bus.timer_active); end
    btn[2] = 1'b1;
    step();
    btn = '0;
    step();
    checks++; if (bus.move_made !== 1'b0) begin errors++; $display("[TB] FAIL drop_latency_early: got %b expected 0", bus.move_made); end
    step();
    checks++; if (bus.move_made !== 1'b1) begin errors++; $display("[TB] FAIL drop_pulse: got %b expected 1", bus.move_made); end
    step();
    checks++; if (bus.move_made !== 1'b0) begin errors++; $display("[TB] FAIL drop_width: got %b expected 0", bus.move_made); end
    checks++; if (bus.timer_active !== 1'b0) begin errors++; $display("[TB] FAIL drop_active_fall: got %b expected 0", bus.timer_active); end
    checks++; if (bus.seconds_left !== 4'd2) begin errors++; $display("[TB] FAIL drop_freeze: got %0d expected 2", bus.seconds_left); end
    ack();
  endtask

  task automatic test_navigation;
    arm();
    btn[0] = 1'b1;
    step();
    btn = '0;
    step();
    step();
    checks++; if (bus.move_left !== 1'b1) begin errors++; $display("[TB] FAIL left_pulse: got %b expected 1", bus.move_left); end
    checks++; if (bus.move_right !== 1'b0) begin errors++; $display("[TB] FAIL left_no_right: got %b expected 0", bus.move_right); end
    step();
    checks++; if (bus.move_left !== 1'b0) begin errors++; $display("[TB] FAIL left_width: got %b expected 0", bus.move_left); end
    checks++; if (bus.seconds_left !== 4'd2) begin errors++; $display("[TB] FAIL left_no_reload: got %0d expected 2", bus.seconds_left); end
    btn = 6'b000011;
    step();
    btn = '0;
    cnt = 0;
    repeat (3) begin step(); cnt += int'(bus.move_left) + int'(bus.move_right); end
    checks++; if (cnt !== 0) begin errors++; $display("[TB] FAIL left_right_conflict: got %0d pulses expected 0", cnt); end
    checks++; if (bus.seconds_left !== 4'd1) begin errors++; $display("[TB] FAIL nav_counting: got %0d expected 1", bus.seconds_left); end
    btn = 6'b000101;
    step();
    btn = '0;
    step();
    step();
    checks++; if (bus.move_made !== 1'b1) begin errors++; $display("[TB] FAIL drop_left_made: got %b expected 1", bus.move_made); end
    checks++; if (bus.move_left !== 1'b0) begin errors++; $display("[TB] FAIL drop_left_no_left: got %b expected 0", bus.move_left); end
    ack();
  endtask

  task automatic test_back_to_back;
    bus.player_turn = 1'b1;
    arm();
    btn[3] = 1'b1;
    step();
    btn = '0;
    step();
    btn[3] = 1'b1;
    step();
    btn = '0;
    cnt = int'(bus.move_left);
    repeat (3) begin step(); cnt += int'(bus.move_left); end
    checks++; if (cnt !== 2) begin errors++; $display("[TB] FAIL back_to_back_p2_left: got %0d pulses expected 2", cnt); end
    bus.player_turn = 1'b0;
    ack();
  endtask

  task automatic test_drop_boundary;
    arm();
    repeat (9) step();
    btn[2] = 1'b1;
    step();
    btn = '0;
    step();
    checks++; if (bus.seconds_left !== 4'd1) begin errors++; $display("[TB] FAIL boundary_pre_sec: got %0d expected 1", bus.seconds_left); end
    step();
    checks++; if (bus.move_made !== 1'b1) begin errors++; $display("[TB] FAIL boundary_made: got %b expected 1", bus.move_made); end
    checks++; if (bus.times_up !== 1'b0) begin errors++; $display("[TB] FAIL boundary_times_up: got %b expected 0", bus.times_up); end
    checks++; if (bus.seconds_left !== 4'd1) begin errors++; $display("[TB] FAIL boundary_sec: got %0d expected 1", bus.seconds_left); end
    step();
    checks++; if (bus.times_up !== 1'b0) begin errors++; $display("[TB] FAIL boundary_late_times_up: got %b expected 0", bus.times_up); end
    ack();
  endtask

  task automatic test_held_button;
    btn[2] = 1'b1;
    repeat (3) step();
    arm();
    cnt = 0;
    repeat (4) begin step(); cnt += int'(bus.move_made); end
    checks++; if (cnt !== 0) begin errors++; $display("[TB] FAIL held_drop: got %0d pulses expected 0", cnt); end
    btn = '0;
    repeat (3) step();
    btn[2] = 1'b1;
    step();
    btn = '0;
    cnt = 0;
    repeat (4) begin step(); cnt += int'(bus.move_made); end
    checks++; if (cnt !== 1) begin errors++; $display("[TB] FAIL repress_drop: got %0d pulses expected 1", cnt); end
    ack();
  endtask

  task automatic test_win_lock;
    arm();
    repeat (2) step();
    bus.win_flag = 1'b1;
    step();
    checks++; if (bus.timer_active !== 1'b0) begin errors++; $display("[TB] FAIL win_active: got %b expected 0", bus.timer_active); end
    checks++; if (bus.seconds_left !== 4'd0) begin errors++; $display("[TB] FAIL win_seconds: got %0d expected 0", bus.seconds_left); end
    bus.win_flag = 1'b0;
    bus.fsm_state = 3'd0;
    step();
    bus.fsm_state = 3'd1;
    btn[2] = 1'b1;
    step();
    btn = '0;
    cnt = 0;
    repeat (16) begin
      step();
      cnt += int'(bus.move_made) + int'(bus.times_up) + int'(bus.timer_active);
    end
    checks++; if (cnt !== 0) begin errors++; $display("[TB] FAIL done_locked: got %0d events expected 0", cnt); end
    checks++; if (bus.seconds_left !== 4'd0) begin errors++; $display("[TB] FAIL done_seconds: got %0d expected 0", bus.seconds_left); end
  endtask

  task automatic test_async_reset;
    reset = 1'b0;
    #2 reset = 1'b1;
    bus.fsm_state = 3'd0;
    step();
    arm();
    repeat (5) step();
    checks++; if (bus.seconds_left !== 4'd2) begin errors++; $display("[TB] FAIL pre_reset_sec: got %0d expected 2", bus.seconds_left); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.seconds_left !== 4'd0) begin errors++; $display("[TB] FAIL async_reset_sec: got %0d expected 0", bus.seconds_left); end
    checks++; if (bus.timer_active !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_active: got %b expected 0", bus.timer_active); end
    #1 reset = 1'b1;
    step();
    checks++; if (bus.timer_active !== 1'b1) begin errors++; $display("[TB] FAIL rearm_active: got %b expected 1", bus.timer_active); end
    checks++; if (bus.seconds_left !== 4'd3) begin errors++; $display("[TB] FAIL rearm_seconds: got %0d expected 3", bus.seconds_left); end
    bus.fsm_state = 3'd0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_timeout();
    test_player_filter();
    test_navigation();
    test_back_to_back();
    test_drop_boundary();
    test_held_button();
    test_win_lock();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
